// File: rtl/glf_mc.sv
// Multi-channel glitch filter / debouncer: 2-flop sync, shared tick prescaler, per-channel hold-time FSM.
// Optional per-channel glitch counters are built when GLF_GLITCH_CNT_EN is defined.
module glf_mc #(
    parameter int unsigned       CH_NUM  = 4,
    parameter int unsigned       CNT_W   = 16,
    parameter int unsigned       CNT1US  = 107,
    parameter logic [CH_NUM-1:0] RST_VAL = {CH_NUM{1'b1}}
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic [CNT_W-1:0]    flt_len,
    input  logic [CH_NUM-1:0]   s_in,
    output logic [CH_NUM-1:0]   s_out,
    output logic [CH_NUM-1:0]   s_rise,
`ifdef GLF_GLITCH_CNT_EN
    output logic [CH_NUM-1:0]   s_fall,
    input  logic                gl_clr,
    output logic [8*CH_NUM-1:0] gl_cnt
`else
    output logic [CH_NUM-1:0]   s_fall
`endif
);

    localparam int unsigned PRE_W = (CNT1US > 1) ? $clog2(CNT1US) : 1;
    localparam int unsigned CMP_W = CNT_W + 1;

    typedef enum logic {
        ST_STABLE  = 1'b0,
        ST_PENDING = 1'b1
    } state_t;

    logic [PRE_W-1:0]  pre;
    logic              tick_c;
    logic [CH_NUM-1:0] sync1;
    logic [CH_NUM-1:0] s_sync;
    state_t            st  [CH_NUM];
    logic [CNT_W-1:0]  cnt [CH_NUM];
    logic              bypass_c;
    logic [CH_NUM-1:0] reach_c;
    logic [CH_NUM-1:0] abort_c;

    assign tick_c   = en && (pre == PRE_W'(CNT1US - 1));
    assign bypass_c = (flt_len == '0);

    // Shared prescaler: one tick per CNT1US enabled cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre <= '0;
        end else if (en) begin
            pre <= tick_c ? '0 : pre + PRE_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1  <= RST_VAL;
            s_sync <= RST_VAL;
        end else if (en) begin
            sync1  <= s_in;
            s_sync <= sync1;
        end
    end

    // Widened compare so cnt+1 cannot wrap at saturation.
    always_comb begin
        reach_c = '0;
        abort_c = '0;
        for (int i = 0; i < CH_NUM; i++) begin
            reach_c[i] = (CMP_W'(cnt[i]) + CMP_W'(1)) >= CMP_W'(flt_len);
            abort_c[i] = en && !bypass_c && (st[i] == ST_PENDING) && (s_sync[i] == s_out[i]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_out  <= RST_VAL;
            s_rise <= '0;
            s_fall <= '0;
            for (int i = 0; i < CH_NUM; i++) begin
                st[i]  <= ST_STABLE;
                cnt[i] <= '0;
            end
        end else begin
            s_rise <= '0;
            s_fall <= '0;
            if (en) begin
                for (int i = 0; i < CH_NUM; i++) begin
                    if (bypass_c) begin
                        st[i]  <= ST_STABLE;
                        cnt[i] <= '0;
                        if (s_sync[i] != s_out[i]) begin
                            s_out[i]  <= s_sync[i];
                            s_rise[i] <= s_sync[i];
                            s_fall[i] <= ~s_sync[i];
                        end
                    end else begin
                        case (st[i])
                            ST_STABLE: begin
                                cnt[i] <= '0;
                                if (s_sync[i] != s_out[i]) begin
                                    st[i] <= ST_PENDING;
                                end
                            end
                            ST_PENDING: begin
                                if (abort_c[i]) begin
                                    st[i]  <= ST_STABLE;
                                    cnt[i] <= '0;
                                end else if (tick_c) begin
                                    if (reach_c[i]) begin
                                        s_out[i]  <= s_sync[i];
                                        s_rise[i] <= s_sync[i];
                                        s_fall[i] <= ~s_sync[i];
                                        st[i]     <= ST_STABLE;
                                        cnt[i]    <= '0;
                                    end else if (cnt[i] != {CNT_W{1'b1}}) begin
                                        cnt[i] <= cnt[i] + CNT_W'(1);
                                    end
                                end
                            end
                            default: begin
                                st[i]  <= ST_STABLE;
                                cnt[i] <= '0;
                            end
                        endcase
                    end
                end
            end
        end
    end

`ifdef GLF_GLITCH_CNT_EN
    // Clear has priority over a same-cycle abort.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gl_cnt <= '0;
        end else if (gl_clr) begin
            gl_cnt <= '0;
        end else begin
            for (int i = 0; i < CH_NUM; i++) begin
                if (abort_c[i] && (gl_cnt[8*i +: 8] != 8'hFF)) begin
                    gl_cnt[8*i +: 8] <= gl_cnt[8*i +: 8] + 8'd1;
                end
            end
        end
    end
`endif

endmodule
